// File: rtl/dram_block_responder.sv
// Block-level DRAM responder: one read/word-write at a time, fixed LATENCY to a one-cycle complete pulse.
// Optional `DRAM_RESP_ERR_EN adds an err output flagging out-of-range block addresses.
module dram_block_responder #(
    parameter int ADDR_W     = 8,
    parameter int NUM_BLOCKS = 256,
    parameter int LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [1:0]        offset,
    input  logic [31:0]       din,
    output logic [127:0]      dout,
    output logic              complete
`ifdef DRAM_RESP_ERR_EN
    ,
    output logic              err
`endif
);

    localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
    localparam logic [ADDR_W:0]  NB_L     = (ADDR_W + 1)'(NUM_BLOCKS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    logic [127:0]      mem_q [NUM_BLOCKS];

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        offset_q, offset_d;
    logic [31:0]       din_q, din_d;
    logic              we_q, we_d;
    logic [127:0]      dout_q, dout_d;
    logic              complete_q, complete_d;

    logic              in_range;
    logic              access;
    logic [127:0]      blk_rd;
    logic [127:0]      blk_merged;

    assign in_range = ({1'b0, addr_q} < NB_L);
    assign access   = (state_q == S_WAIT) && (cnt_q == '0);
    assign blk_rd   = mem_q[addr_q[IDX_W-1:0]];

    // Write is merged before the read so a combined re+we returns the post-write block.
    always_comb begin
        blk_merged = blk_rd;
        if (we_q) begin
            blk_merged[{offset_q, 5'b0} +: 32] = din_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        offset_d   = offset_q;
        din_d      = din_q;
        we_d       = we_q;
        dout_d     = dout_q;
        complete_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (re || we) begin
                    addr_d   = addr;
                    offset_d = offset;
                    din_d    = din;
                    we_d     = we;
                    cnt_d    = CNT_LOAD;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    dout_d     = in_range ? blk_merged : '0;
                    complete_d = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            dout_q     <= '0;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dout_q     <= dout_d;
            complete_q <= complete_d;
        end
    end

    // Request latches carry data only; they are always reloaded before use.
    always_ff @(posedge clk) begin
        addr_q   <= addr_d;
        offset_q <= offset_d;
        din_q    <= din_d;
        we_q     <= we_d;
    end

    always_ff @(posedge clk) begin
        if (access && we_q && in_range) begin
            mem_q[addr_q[IDX_W-1:0]] <= blk_merged;
        end
    end

    assign dout     = dout_q;
    assign complete = complete_q;

`ifdef DRAM_RESP_ERR_EN
    logic err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= access && !in_range;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_dram_block_responder.sv
// Directed bench for dram_block_responder (NUM_BLOCKS=200, LATENCY=4); checks err when DRAM_RESP_ERR_EN is defined.
module tb_dram_block_responder;

    localparam int LAT = 4;
    localparam logic [127:0] ONES = {128{1'b1}};
    localparam logic [127:0] B5   = 128'h44444444_DEADBEEF_22222222_11111111;
    localparam logic [127:0] B7   = 128'h00000073_00000072_00000071_00000070;

    logic         clk = 1'b0;
    logic         rst;
    logic         re;
    logic         we;
    logic [7:0]   addr;
    logic [1:0]   offset;
    logic [31:0]  din;
    logic [127:0] dout;
    logic         complete;
`ifdef DRAM_RESP_ERR_EN
    logic         err;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    dram_block_responder #(
        .ADDR_W(8),
        .NUM_BLOCKS(200),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .re(re),
        .we(we),
        .addr(addr),
        .offset(offset),
        .din(din),
        .dout(dout),
        .complete(complete)
`ifdef DRAM_RESP_ERR_EN
        ,
        .err(err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_err(input string tag, input logic exp);
`ifdef DRAM_RESP_ERR_EN
        chk(tag, {127'b0, err}, {127'b0, exp});
`else
        if (exp === 1'bx) $display("unused %s", tag);
`endif
    endtask

    // Request, then scramble inputs during WAIT; complete must appear exactly LAT edges after acceptance.
    task automatic txn(input logic r, input logic w, input logic [7:0] a, input logic [1:0] off,
                       input logic [31:0] d, input logic [127:0] exp_dout, input logic [127:0] mask,
                       input logic exp_err, input string tag);
        re = r; we = w; addr = a; offset = off; din = d;
        @(posedge clk); #1;
        for (int k = 1; k <= LAT + 1; k++) begin
            if (k <= LAT) begin
                re = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1));
                addr = 8'($urandom); offset = 2'($urandom); din = $urandom;
            end else begin
                re = 1'b0; we = 1'b0;
            end
            @(posedge clk); #1;
            if (k == LAT) begin
                chk({tag, "_complete"}, {127'b0, complete}, 128'd1);
                chk({tag, "_dout"}, dout & mask, exp_dout & mask);
                chk_err({tag, "_err"}, exp_err);
            end else begin
                chk({tag, "_idle_complete"}, {127'b0, complete}, 128'd0);
                chk_err({tag, "_idle_err"}, 1'b0);
            end
        end
    endtask

    initial begin
        rst = 1'b1; re = 1'b0; we = 1'b0; addr = '0; offset = '0; din = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_complete", {127'b0, complete}, 128'd0);
        chk("reset_dout", dout, 128'd0);
        chk_err("reset_err", 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Build block 5 word by word; unknown words are masked until written.
        txn(0, 1, 8'd5, 2'd0, 32'h11111111, 128'h11111111, 128'hFFFFFFFF, 0, "wr5_w0");
        txn(0, 1, 8'd5, 2'd1, 32'h22222222, 128'h22222222_11111111, {64'b0, {64{1'b1}}}, 0, "wr5_w1");
        txn(0, 1, 8'd5, 2'd3, 32'h44444444, 128'h44444444_00000000_22222222_11111111,
            {{32{1'b1}}, 32'b0, {64{1'b1}}}, 0, "wr5_w3");
        txn(0, 1, 8'd5, 2'd2, 32'hDEADBEEF, B5, ONES, 0, "wr5_w2");
        txn(1, 0, 8'd5, 2'd0, 32'h0, B5, ONES, 0, "rd5");

        // Block 3 zeroed, then combined re+we returns the merged block.
        txn(0, 1, 8'd3, 2'd1, 32'h0, 128'h0, {64'b0, {32{1'b1}}, 32'b0}, 0, "wr3_w1");
        txn(0, 1, 8'd3, 2'd2, 32'h0, 128'h0, {32'b0, {32{1'b1}}, 64'b0}, 0, "wr3_w2");
        txn(0, 1, 8'd3, 2'd3, 32'h0, 128'h0, {{32{1'b1}}, 96'b0}, 0, "wr3_w3");
        txn(0, 1, 8'd3, 2'd0, 32'h0, 128'h0, ONES, 0, "wr3_w0");
        txn(1, 1, 8'd3, 2'd0, 32'h1234, 128'h1234, ONES, 0, "rw3");

        // Block 7 known contents, then an interrupted write.
        txn(0, 1, 8'd7, 2'd0, 32'h70, 128'h70, 128'hFFFFFFFF, 0, "wr7_w0");
        txn(0, 1, 8'd7, 2'd1, 32'h71, 128'h71_00000070, {64'b0, {64{1'b1}}}, 0, "wr7_w1");
        txn(0, 1, 8'd7, 2'd2, 32'h72, 128'h72_00000071_00000070, {32'b0, {96{1'b1}}}, 0, "wr7_w2");
        txn(0, 1, 8'd7, 2'd3, 32'h73, B7, ONES, 0, "wr7_w3");

        re = 1'b0; we = 1'b1; addr = 8'd7; offset = 2'd1; din = 32'hFFFFFFFF;
        @(posedge clk); #1;
        we = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrst_complete", {127'b0, complete}, 128'd0);
        chk("midrst_dout", dout, 128'd0);
        chk_err("midrst_err", 1'b0);
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("midrst_hold_complete", {127'b0, complete}, 128'd0);
        end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            chk("postrst_complete", {127'b0, complete}, 128'd0);
            chk("postrst_dout", dout, 128'd0);
        end
        txn(1, 0, 8'd7, 2'd0, 32'h0, B7, ONES, 0, "rd7_after_rst");

        // Held read: second completion LAT+2 edges after the first.
        re = 1'b1; we = 1'b0; addr = 8'd5; offset = 2'd0; din = 32'h0;
        @(posedge clk); #1;
        for (int k = 1; k <= 2 * LAT + 5; k++) begin
            @(posedge clk); #1;
            if (k == LAT || k == 2 * LAT + 2) begin
                chk("held_complete_hi", {127'b0, complete}, 128'd1);
                chk("held_dout", dout, B5);
            end else begin
                chk("held_complete_lo", {127'b0, complete}, 128'd0);
            end
            if (k == 2 * LAT + 2) re = 1'b0;
        end

        // Out-of-range and boundary addresses.
        txn(0, 1, 8'd210, 2'd0, 32'hCAFEF00D, 128'h0, ONES, 1, "oor_wr210");
        txn(1, 0, 8'd210, 2'd0, 32'h0, 128'h0, ONES, 1, "oor_rd210");
        txn(1, 0, 8'd200, 2'd0, 32'h0, 128'h0, ONES, 1, "oor_rd200");
        txn(0, 1, 8'd199, 2'd0, 32'hAAAA5555, 128'hAAAA5555, 128'hFFFFFFFF, 0, "wr199");
        txn(1, 0, 8'd3, 2'd0, 32'h0, 128'h1234, ONES, 0, "rd3_final");
        txn(1, 0, 8'd5, 2'd0, 32'h0, B5, ONES, 0, "rd5_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
